cog_vidq: RTL and testbench
===========================

// Module: cog_vidq
// PURPOSE
//  Queued, parametrised cog video shifter. Accepts {pixel,color} sets from the cog via a
//  valid/ready handshake into a DEPTH-entry FIFO, so several WAITVID sets can be buffered.
//  Serialises each set at 1 or 2 bits per pixel, in either bit order, into a CW-bit colour
//  stream. Frames change back-to-back with no gap; underrun is detected and flagged.
//  Sits between the cog WAITVID path and the pin/DAC encoders.
// PARAMETERS
//  DEPTH  4   FIFO entries; power of two, >=2
//  CW     8   bits per colour entry; color word is 4*CW bits
//  LW     3   width of fifo_level, = clog2(DEPTH+1)
// PORTS
//  clk_vid     in   1     video clock, sole clock
//  nres        in   1     async active-low reset
//  ena         in   1     sync enable; low = flush queue, stop shifter, idle outputs
//  cfg_bpp2    in   1     0 = 1 bit/pixel (2 colours), 1 = 2 bits/pixel (4 colours)
//  cfg_msb     in   1     0 = consume pixel bits from bit0 (shift right), 1 = from bit31
//  scl_ppc     in   8     clocks per pixel; 0 means 256
//  scl_cpf     in   12    clocks per frame (set); 0 means 4096
//  idle_color  in   CW    colour driven while no frame is active
//  in_valid    in   1     set offered
//  in_ready    out  1     set accepted when in_valid & in_ready
//  in_pixel    in   32    pixel word
//  in_color    in   4*CW  colour table; entry i = in_color[i*CW +: CW]
//  vid_out     out  CW    registered colour output
//  vid_active  out  1     vid_out is from a frame (not idle_color)
//  underrun    out  1     one-clock pulse: frame ended with FIFO empty
//  fifo_level  out  LW    stored entries, 0..DEPTH
// BEHAVIOUR
//  Reset (nres=0, async): FIFO empty, state IDLE; vid_out=0, vid_active=0,
//   underrun=0, fifo_level=0, in_ready=0.
//  FIFO: in_ready = ena & (fifo_level != DEPTH). No fall-through: a pushed entry becomes
//   poppable the clock after the push. Push and pop in the same clock are allowed
//   (level unchanged). Pointers wrap modulo DEPTH.
//  Load: pop head into pixels/colors; latch cfg_bpp2, cfg_msb, scl_ppc into frame regs;
//   set := scl_cpf, cnt := scl_ppc. Config/scale changes only take effect at a load.
//  States:
//   IDLE: if ena & level!=0 -> load, go RUN. Push at clock t -> pop at t+1 ->
//    first vid_out/vid_active=1 at t+2.
//   RUN, every clock: set--, cnt--.
//    cnt==1 & set!=1: shift pixels by 1 or 2; cnt := latched ppc.
//    set==1 & level!=0: load next set on this edge (seamless; next frame's first colour
//     appears the following clock).
//    set==1 & level==0: go IDLE; underrun=1 for exactly one clock. From the next clock:
//     vid_out=idle_color, vid_active=0.
//   Frame end wins over a simultaneous cnt==1.
//  Pixel index:
//   cfg_msb=0: idx = bpp2 ? pixels[1:0] : pixels[0]. Shift right; vacated top bits
//    replicate bit31 (1bpp) or bits31:30 (2bpp).
//   cfg_msb=1: idx = bpp2 ? pixels[31:30] : pixels[31]. Shift left; vacated low bits
//    replicate bit0 or bits1:0.
//   1bpp uses colour entries 0/1 only.
//  vid_out: registered every clock; = colors[idx*CW +: CW] in RUN, idle_color in IDLE.
//  Counters: counters are full width; counters loaded with 0 run the full 256/4096 count.
//  ena low: synchronous flush. Next edge: FIFO empty, IDLE, vid_out=0, vid_active=0,
//   underrun=0, in_ready=0. A push offered in that cycle is dropped. No underrun is
//   reported for the flush.
// TESTING
//  1 Reset mid-frame: assert nres=0 while RUN -> all outputs 0 immediately (async);
//    after release, level=0 and IDLE.
//  2 1bpp LSB-first: ppc=2, cpf=8, pixel=0x000000A5, color=0x44332211 ->
//    vid_out 22,22,11,11,22,22,11,11; then underrun pulse and idle_color.
//  3 2bpp MSB-first: ppc=1, cpf=4, pixel=0xE4000000, color=0x44332211 ->
//    vid_out 44,33,22,11.
//  4 Back-to-back: queue two sets with cpf=4 -> 8 consecutive active clocks, no gap,
//    no underrun until after the 8th; the second set's cfg changes are honoured.
//  5 Full/backpressure: DEPTH=4, cpf=0, push 6 sets continuously -> 1 popped, level=4,
//    in_ready=0; the 6th set is held until a pop frees a slot.
//  6 ena low mid-frame with level=3 -> next clock: level=0, vid_out=0, no underrun pulse;
//    ena high plus a new push -> restarts with 2-clock latency.

Source files
------------

// File: rtl/cog_vidq.sv
// Queued cog video shifter: a DEPTH-entry {pixel,color} FIFO feeding a 1/2 bpp serialiser
// that emits one CW-bit colour per clock, chaining frames seamlessly and flagging underrun.
module cog_vidq #(
  parameter int DEPTH = 4,
  parameter int CW    = 8,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic              clk_vid,
  input  logic              nres,
  input  logic              ena,
  input  logic              cfg_bpp2,
  input  logic              cfg_msb,
  input  logic [7:0]        scl_ppc,
  input  logic [11:0]       scl_cpf,
  input  logic [CW-1:0]     idle_color,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pixel,
  input  logic [4*CW-1:0]   in_color,
  output logic [CW-1:0]     vid_out,
  output logic              vid_active,
  output logic              underrun,
  output logic [LW-1:0]     fifo_level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  logic [31:0]     pix_mem [DEPTH];
  logic [4*CW-1:0] col_mem [DEPTH];

  state_t          state_q, state_d;
  logic [PW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0]   level_q, level_d;
  logic [CW-1:0]   vid_out_q, vid_out_d;
  logic            vid_active_q, vid_active_d;
  logic            underrun_q, underrun_d;

  logic [31:0]     pix_q, pix_d;
  logic [4*CW-1:0] col_q, col_d;
  logic            bpp2_q, bpp2_d, msb_q, msb_d;
  logic [7:0]      ppc_q, ppc_d, cnt_q, cnt_d;
  logic [11:0]     set_q, set_d;

  logic            push, pop, nonempty, frame_end;
  logic [1:0]      idx;

  assign in_ready   = ena & nres & (level_q != LW'(DEPTH));
  assign vid_out    = vid_out_q;
  assign vid_active = vid_active_q;
  assign underrun   = underrun_q;
  assign fifo_level = level_q;

  always_comb begin
    push      = in_valid & in_ready;
    nonempty  = (level_q != '0);
    frame_end = (state_q == RUN) && (set_q == 12'd1);
    pop       = ena & nonempty & ((state_q == IDLE) | frame_end);

    if (bpp2_q) idx = msb_q ? pix_q[31:30] : pix_q[1:0];
    else        idx = {1'b0, (msb_q ? pix_q[31] : pix_q[0])};

    state_d      = state_q;
    wp_d         = wp_q;
    rp_d         = rp_q;
    level_d      = level_q;
    vid_out_d    = vid_out_q;
    vid_active_d = vid_active_q;
    underrun_d   = 1'b0;
    pix_d        = pix_q;
    col_d        = col_q;
    bpp2_d       = bpp2_q;
    msb_d        = msb_q;
    ppc_d        = ppc_q;
    cnt_d        = cnt_q;
    set_d        = set_q;

    if (!ena) begin
      // Flush: queue and shifter cleared, outputs forced quiet, no underrun reported
      state_d      = IDLE;
      wp_d         = '0;
      rp_d         = '0;
      level_d      = '0;
      vid_out_d    = '0;
      vid_active_d = 1'b0;
    end else begin
      if (push) wp_d = wp_q + PW'(1);
      if (pop)  rp_d = rp_q + PW'(1);
      level_d = level_q + LW'(push) - LW'(pop);

      if (state_q == IDLE) begin
        vid_out_d    = idle_color;
        vid_active_d = 1'b0;
      end else begin
        vid_out_d    = col_q[idx*CW +: CW];
        vid_active_d = 1'b1;
        set_d        = set_q - 12'd1;
        cnt_d        = cnt_q - 8'd1;
        if (frame_end) begin
          if (!nonempty) begin
            state_d    = IDLE;
            underrun_d = 1'b1;
          end
        end else if (cnt_q == 8'd1) begin
          cnt_d = ppc_q;
          // Vacated bits replicate the far-end pixel so an over-long frame repeats it
          if (msb_q) pix_d = bpp2_q ? {pix_q[29:0], pix_q[1:0]} : {pix_q[30:0], pix_q[0]};
          else       pix_d = bpp2_q ? {pix_q[31:30], pix_q[31:2]} : {pix_q[31], pix_q[31:1]};
        end
      end

      if (pop) begin
        state_d = RUN;
        pix_d   = pix_mem[rp_q];
        col_d   = col_mem[rp_q];
        bpp2_d  = cfg_bpp2;
        msb_d   = cfg_msb;
        ppc_d   = scl_ppc;
        cnt_d   = scl_ppc;
        set_d   = scl_cpf;
      end
    end
  end

  always_ff @(posedge clk_vid or negedge nres) begin
    if (!nres) begin
      state_q      <= IDLE;
      wp_q         <= '0;
      rp_q         <= '0;
      level_q      <= '0;
      vid_out_q    <= '0;
      vid_active_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      level_q      <= level_d;
      vid_out_q    <= vid_out_d;
      vid_active_q <= vid_active_d;
      underrun_q   <= underrun_d;
    end
  end

  // Datapath state: only meaningful while RUN, so left out of reset
  always_ff @(posedge clk_vid) begin
    if (push) begin
      pix_mem[wp_q] <= in_pixel;
      col_mem[wp_q] <= in_color;
    end
    pix_q  <= pix_d;
    col_q  <= col_d;
    bpp2_q <= bpp2_d;
    msb_q  <= msb_d;
    ppc_q  <= ppc_d;
    cnt_q  <= cnt_d;
    set_q  <= set_d;
  end

endmodule

// File: tb/tb_cog_vidq.sv
// Randomised and directed bench for cog_vidq: stimulus queues accepted sets, a monitor
// rebuilds each frame's colour stream from the pixel/colour rules and compares it.
module tb_cog_vidq;

  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int LW    = 3;

  logic              clk_vid = 1'b0;
  logic              nres = 1'b0;
  logic              ena = 1'b0;
  logic              cfg_bpp2 = 1'b0;
  logic              cfg_msb = 1'b0;
  logic [7:0]        scl_ppc = 8'd1;
  logic [11:0]       scl_cpf = 12'd1;
  logic [CW-1:0]     idle_color = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_pixel = '0;
  logic [4*CW-1:0]   in_color = '0;
  logic [CW-1:0]     vid_out;
  logic              vid_active;
  logic              underrun;
  logic [LW-1:0]     fifo_level;

  cog_vidq #(.DEPTH(DEPTH), .CW(CW), .LW(LW)) dut (
    .clk_vid(clk_vid), .nres(nres), .ena(ena), .cfg_bpp2(cfg_bpp2), .cfg_msb(cfg_msb),
    .scl_ppc(scl_ppc), .scl_cpf(scl_cpf), .idle_color(idle_color), .in_valid(in_valid),
    .in_ready(in_ready), .in_pixel(in_pixel), .in_color(in_color), .vid_out(vid_out),
    .vid_active(vid_active), .underrun(underrun), .fifo_level(fifo_level)
  );

  always #5 clk_vid = ~clk_vid;

  typedef struct {
    logic [31:0]     pix;
    logic [4*CW-1:0] col;
    int              acc;
  } frame_t;

  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  frame_t frame_q[$];
  logic [21:0] cfg_hist [int];

  // monitor state
  logic   armed = 1'b0;
  logic   flush_chk = 1'b0;
  logic   in_frame = 1'b0;
  int     exp_next = 0;   // 0 none, 1 idle expected, 2 next frame expected without gap
  frame_t cur;
  logic   cur_bpp2, cur_msb;
  logic [7:0] cur_ppc;
  int     cur_cpf, k;

  always @(posedge clk_vid) cyc <= cyc + 1;

  // configuration seen by the upcoming edge, used when a frame's load edge is known
  always @(negedge clk_vid) begin
    #3;
    cfg_hist[cyc + 1] = {cfg_bpp2, cfg_msb, scl_ppc, scl_cpf};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [CW-1:0] model_color(input logic [31:0] pix, input logic [4*CW-1:0] col,
                                                input logic bpp2, input logic msb,
                                                input logic [7:0] ppc, input int kk);
    int eff, sh, pos, idx;
    logic [4*CW-1:0] c;
    eff = (ppc == 8'd0) ? 256 : int'(ppc);
    sh  = kk / eff;
    if (!bpp2) begin
      pos = (sh > 31) ? 31 : sh;
      idx = msb ? int'(pix[31-pos]) : int'(pix[pos]);
    end else begin
      pos = (sh > 15) ? 15 : sh;
      idx = msb ? int'((pix >> (30 - 2*pos)) & 32'd3) : int'((pix >> (2*pos)) & 32'd3);
    end
    c = col >> (idx * CW);
    return c[CW-1:0];
  endfunction

  always @(negedge clk_vid) begin
    if (armed) begin
      if (flush_chk) begin
        flush_chk = 1'b0;
        chk("flush_state", {vid_active, underrun, vid_out, fifo_level}, 64'd0);
      end else if (exp_next == 1) begin
        exp_next = 0;
        chk("idle_after_underrun", {vid_active, vid_out}, {1'b0, idle_color});
      end else begin
        if (exp_next == 2) begin
          exp_next = 0;
          chk("no_gap", vid_active, 1'b1);
        end
        if (vid_active) begin
          if (!in_frame) begin
            if (frame_q.size() == 0) begin
              chk("unexpected_active", vid_active, 1'b0);
            end else begin
              logic [21:0] h;
              cur = frame_q.pop_front();
              h = cfg_hist[cyc - 1];
              cur_bpp2 = h[21];
              cur_msb  = h[20];
              cur_ppc  = h[19:12];
              cur_cpf  = (h[11:0] == 12'd0) ? 4096 : int'(h[11:0]);
              k = 0;
              in_frame = 1'b1;
            end
          end
          if (in_frame) begin
            logic last, exp_u;
            last  = (k == cur_cpf - 1);
            exp_u = last && !(frame_q.size() > 0 && frame_q[0].acc < cyc);
            chk("pixel", {vid_out, underrun},
                {model_color(cur.pix, cur.col, cur_bpp2, cur_msb, cur_ppc, k), exp_u});
            k++;
            if (last) begin
              in_frame = 1'b0;
              exp_next = exp_u ? 1 : 2;
            end
          end
        end
      end
    end
  end

  task automatic step(output logic hs);
    #1;
    hs = in_valid && in_ready;
    if (hs) frame_q.push_back('{in_pixel, in_color, cyc + 1});
    @(negedge clk_vid);
    #1;
  endtask

  task automatic tick();
    logic hs;
    step(hs);
  endtask

  task automatic push_set(input logic [31:0] p, input logic [4*CW-1:0] c, input int bound,
                          output int acc);
    logic hs;
    int n;
    in_valid = 1'b1;
    in_pixel = p;
    in_color = c;
    hs = 1'b0;
    acc = -1;
    for (n = 0; n < bound && !hs; n++) begin
      step(hs);
      if (hs) acc = cyc;
    end
    in_valid = 1'b0;
    if (!hs) chk("push_timeout", 64'(n), 64'(bound + 1));
  endtask

  task automatic do_flush();
    ena = 1'b0;
    in_valid = 1'b1;
    in_pixel = $urandom;
    in_color = $urandom;
    frame_q.delete();
    in_frame = 1'b0;
    exp_next = 0;
    flush_chk = 1'b1;
    tick();
    ena = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((frame_q.size() != 0 || in_frame) && n < 20000) begin
      tick();
      n++;
    end
    tick();
    tick();
    tick();
    chk("drain_done", 64'(n < 20000), 64'd1);
  endtask

  task automatic set_cfg(input logic b, input logic m, input logic [7:0] p, input logic [11:0] f);
    cfg_bpp2 = b;
    cfg_msb  = m;
    scl_ppc  = p;
    scl_cpf  = f;
  endtask

  // from an idle queue: level 1 after the push, load next clock, first colour the clock after
  task automatic latency_check(input logic [CW-1:0] first);
    chk("lat_level", fifo_level, 64'd1);
    chk("lat_push_clk", vid_active, 1'b0);
    tick();
    chk("lat_load_clk", vid_active, 1'b0);
    tick();
    chk("lat_first_active", {vid_active, vid_out}, {1'b1, first});
  endtask

  initial begin
    int acc, acc1, acc6, held;
    logic hs;
    idle_color = 8'h5A;
    #1;
    chk("rst_vid_out", vid_out, 64'd0);
    chk("rst_vid_active", vid_active, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_level", fifo_level, 64'd0);
    chk("rst_in_ready", in_ready, 1'b0);
    @(negedge clk_vid);
    #1;
    nres = 1'b1;
    ena = 1'b1;
    tick();
    tick();
    chk("idle_color_out", {vid_active, vid_out}, {1'b0, idle_color});
    armed = 1'b1;

    // 1bpp LSB first: 22,22,11,11,22,22,11,11
    set_cfg(1'b0, 1'b0, 8'd2, 12'd8);
    push_set(32'h0000_00A5, 32'h4433_2211, 10, acc);
    latency_check(8'h22);
    drain();

    // 2bpp MSB first: 44,33,22,11
    set_cfg(1'b1, 1'b1, 8'd1, 12'd4);
    push_set(32'hE400_0000, 32'h4433_2211, 10, acc);
    latency_check(8'h44);
    drain();

    // back-to-back sets, second with a different configuration
    set_cfg(1'b0, 1'b0, 8'd1, 12'd4);
    push_set($urandom, $urandom, 10, acc);
    push_set($urandom, $urandom, 10, acc);
    tick();
    set_cfg(1'b1, 1'b1, 8'd2, 12'd4);
    drain();

    // full queue with 4096-clock frames: sixth set held until the first frame ends
    set_cfg(1'b0, 1'b1, 8'd1, 12'd0);
    push_set($urandom, $urandom, 10, acc1);
    for (int i = 0; i < 4; i++) push_set($urandom, $urandom, 10, acc);
    chk("full_level", fifo_level, 64'd4);
    chk("full_in_ready", in_ready, 1'b0);
    in_valid = 1'b1;
    in_pixel = $urandom;
    in_color = $urandom;
    held = 0;
    for (int i = 0; i < 20; i++) begin
      step(hs);
      if (hs) held++;
    end
    chk("full_hold", 64'(held), 64'd0);
    push_set(in_pixel, in_color, 5000, acc6);
    chk("sixth_accept_cycle", 64'(acc6), 64'(acc1 + 4098));
    do_flush();

    // flush mid-frame with three queued, then restart
    set_cfg(1'b1, 1'b0, 8'd3, 12'd40);
    for (int i = 0; i < 4; i++) push_set($urandom, $urandom, 10, acc);
    chk("flush_pre_level", fifo_level, 64'd3);
    for (int i = 0; i < 5; i++) tick();
    do_flush();
    set_cfg(1'b0, 1'b0, 8'd1, 12'd3);
    push_set(32'h0000_0001, 32'h4433_2211, 10, acc);
    latency_check(8'h22);
    drain();

    // randomised traffic, configuration churn and occasional flushes
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0)
        set_cfg(1'($urandom), 1'($urandom), 8'($urandom_range(0, 4)), 12'($urandom_range(1, 12)));
      if ($urandom_range(0, 199) == 0) begin
        do_flush();
      end else begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_pixel = $urandom;
        in_color = $urandom;
        tick();
      end
    end
    in_valid = 1'b0;
    drain();

    // asynchronous reset in the middle of a frame
    set_cfg(1'b1, 1'b0, 8'd5, 12'd100);
    push_set($urandom, $urandom, 10, acc);
    for (int i = 0; i < 6; i++) tick();
    chk("pre_reset_active", vid_active, 1'b1);
    armed = 1'b0;
    #2;
    nres = 1'b0;
    #1;
    chk("async_rst_out", {vid_out, vid_active, underrun, fifo_level, in_ready}, 64'd0);
    frame_q.delete();
    in_frame = 1'b0;
    exp_next = 0;
    @(negedge clk_vid);
    #1;
    nres = 1'b1;
    tick();
    tick();
    chk("post_rst_idle", {fifo_level, vid_active, vid_out}, {3'd0, 1'b0, idle_color});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
